// File: rtl/axis_pkg.sv
// Shared definitions for the voted-stream packet FIFO.
//   DATA_WIDTH_DEFAULT : default tdata width
//   entry_t            : one stored word, {tlast, tdata}, at the default width
//   wr_state_t         : write-side FSM states (ACCEPT, DROP)
package axis_pkg;

  localparam int unsigned DATA_WIDTH_DEFAULT = 16;

  typedef struct packed {
    logic                          last;
    logic [DATA_WIDTH_DEFAULT-1:0] data;
  } entry_t;

  typedef enum logic [0:0] {
    ACCEPT = 1'b0,
    DROP   = 1'b1
  } wr_state_t;

endpackage

// File: rtl/axis_pkt_mem.sv
// Packet storage: DEPTH x WIDTH array, synchronous write, asynchronous read.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data ({tlast, tdata})
//   raddr : read address
//   rdata : combinational read data
module axis_pkt_mem #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axis_vote_packet_fifo.sv
// Store-and-forward AXI-Stream packet FIFO for the voted result stream.
// A packet becomes visible on the output only after its tlast beat has been
// stored; a packet that does not fit is discarded whole and counted.
//   clk, rst             : clock, asynchronous active-high reset
//   s_axis_*             : input stream (never backpressured after reset)
//   m_axis_*             : output stream of committed packets
//   pkt_count            : complete packets currently stored
//   drop_count           : packets dropped since reset, saturating
//   overflow             : one-cycle pulse per dropped packet
module axis_vote_packet_fifo
  import axis_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic [CNT_WIDTH-1:0]  drop_count,
  output logic                  overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } word_t;

  wr_state_t   state, state_next;
  logic        ready_q;
  logic [AW:0] wr_ptr, wr_ptr_next;
  logic [AW:0] wr_commit, wr_commit_next;
  logic [AW:0] rd_ptr;
  logic        full;
  logic        in_fire, out_fire;
  logic        mem_we;
  logic        commit_inc;
  logic        pkt_dec;
  logic        drop;
  word_t       wr_word, rd_word;

  // Occupancy includes uncommitted words; a same-cycle read does not help.
  assign full     = (wr_ptr - rd_ptr) == DEPTH_P;
  assign in_fire  = s_axis_tvalid & ready_q;
  assign out_fire = m_axis_tvalid & m_axis_tready;
  assign wr_word  = '{last: s_axis_tlast, data: s_axis_tdata};

  always_comb begin
    state_next     = state;
    wr_ptr_next    = wr_ptr;
    wr_commit_next = wr_commit;
    mem_we         = 1'b0;
    commit_inc     = 1'b0;
    drop           = 1'b0;
    case (state)
      ACCEPT: begin
        if (in_fire) begin
          if (full) begin
            // Rewind over the partial packet; remaining beats are swallowed.
            drop        = 1'b1;
            wr_ptr_next = wr_commit;
            if (!s_axis_tlast) begin
              state_next = DROP;
            end
          end else begin
            mem_we      = 1'b1;
            wr_ptr_next = wr_ptr + 1'b1;
            if (s_axis_tlast) begin
              wr_commit_next = wr_ptr + 1'b1;
              commit_inc     = 1'b1;
            end
          end
        end
      end
      DROP: begin
        if (in_fire && s_axis_tlast) begin
          state_next = ACCEPT;
        end
      end
      default: state_next = ACCEPT;
    endcase
  end

  axis_pkt_mem #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_word),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_word)
  );

  assign m_axis_tvalid = (rd_ptr != wr_commit);
  assign m_axis_tdata  = rd_word.data;
  assign m_axis_tlast  = rd_word.last;
  assign s_axis_tready = ready_q;
  assign pkt_dec       = out_fire & rd_word.last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ACCEPT;
      ready_q    <= 1'b0;
      wr_ptr     <= '0;
      wr_commit  <= '0;
      rd_ptr     <= '0;
      pkt_count  <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
    end else begin
      state     <= state_next;
      ready_q   <= 1'b1;
      wr_ptr    <= wr_ptr_next;
      wr_commit <= wr_commit_next;
      if (out_fire) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({commit_inc, pkt_dec})
        2'b10:   pkt_count <= pkt_count + 1'b1;
        2'b01:   pkt_count <= pkt_count - 1'b1;
        default: pkt_count <= pkt_count;
      endcase
      overflow <= drop;
      if (drop && (drop_count != '1)) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axis_vote_packet_fifo.sv
module tb_axis_vote_packet_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic          m_axis_tready;

  logic          s_axis_tready, m_axis_tvalid, m_axis_tlast, overflow;
  logic [DW-1:0] m_axis_tdata;
  logic [15:0]   pkt_count, drop_count;

  logic          sat_s_tready, sat_m_tvalid, sat_m_tlast, sat_overflow;
  logic [DW-1:0] sat_m_tdata;
  logic [1:0]    sat_pkt_count, sat_drop_count;

  always #5 clk = ~clk;

  axis_vote_packet_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .pkt_count(pkt_count), .drop_count(drop_count), .overflow(overflow)
  );

  axis_vote_packet_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(sat_s_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(sat_m_tdata), .m_axis_tvalid(sat_m_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(sat_m_tlast),
    .pkt_count(sat_pkt_count), .drop_count(sat_drop_count), .overflow(sat_overflow)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: committed words, words of the packet in progress,
  // drop mode, drop count and the expected overflow/ready flags.
  logic [DW:0] cq[$];
  logic [DW:0] pq[$];
  bit          m_drop_mode;
  bit          m_ov;
  bit          m_ready;
  int          m_drops;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pkts_stored();
    int n = 0;
    foreach (cq[i]) if (cq[i][DW]) n++;
    return n;
  endfunction

  task automatic model_reset();
    cq.delete();
    pq.delete();
    m_drop_mode = 1'b0;
    m_ov        = 1'b0;
    m_ready     = 1'b0;
    m_drops     = 0;
  endtask

  task automatic check_outputs();
    chk("s_tready", s_axis_tready, m_ready);
    chk("m_tvalid", m_axis_tvalid, cq.size() != 0);
    chk("sat_m_tvalid", sat_m_tvalid, cq.size() != 0);
    if (cq.size() != 0) begin
      chk("m_tdata", m_axis_tdata, cq[0][DW-1:0]);
      chk("m_tlast", m_axis_tlast, cq[0][DW]);
    end
    chk("pkt_count", pkt_count, pkts_stored());
    chk("drop_count", drop_count, (m_drops > 65535) ? 65535 : m_drops);
    chk("overflow", overflow, m_ov);
    chk("sat_drop_count", sat_drop_count, (m_drops > 3) ? 3 : m_drops);
    chk("sat_overflow", sat_overflow, m_ov);
  endtask

  // One clock: decide from pre-edge inputs and model state, then compare.
  task automatic step();
    bit          fin, fout, new_ov;
    int          occ;
    logic [DW:0] w;
    fin    = s_axis_tvalid && m_ready;
    fout   = (cq.size() != 0) && m_axis_tready;
    occ    = cq.size() + pq.size();
    w      = {s_axis_tlast, s_axis_tdata};
    new_ov = 1'b0;
    @(posedge clk);
    #1;
    if (fout) void'(cq.pop_front());
    if (fin) begin
      if (!m_drop_mode) begin
        if (occ == DEPTH) begin
          pq.delete();
          m_drops++;
          new_ov = 1'b1;
          if (!w[DW]) m_drop_mode = 1'b1;
        end else begin
          pq.push_back(w);
          if (w[DW]) begin
            foreach (pq[i]) cq.push_back(pq[i]);
            pq.delete();
          end
        end
      end else if (w[DW]) begin
        m_drop_mode = 1'b0;
      end
    end
    m_ov    = new_ov;
    m_ready = 1'b1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic l);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    step();
  endtask

  task automatic send_pkt(input logic [DW-1:0] start, input int len, input int dir);
    for (int i = 0; i < len; i++) send_beat(DW'(int'(start) + dir * i), i == len - 1);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  typedef struct {
    logic          tv;
    logic [DW-1:0] td;
    logic          tl;
    logic          mr;
    logic          ev;
    logic [DW-1:0] ed;
    logic          el;
    int            ep;
  } vec_t;

  vec_t tbl[7];
  int   ov_pulses;

  initial begin
    tbl[0] = '{1'b1, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 0};
    tbl[1] = '{1'b1, 16'h0002, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 0};
    tbl[2] = '{1'b1, 16'h0003, 1'b1, 1'b1, 1'b1, 16'h0001, 1'b0, 1};
    tbl[3] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0002, 1'b0, 1};
    tbl[4] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b0, 1};
    tbl[5] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0003, 1'b1, 1};
    tbl[6] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 0};

    rst           = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    model_reset();
    #1;
    chk("rst_s_tready", s_axis_tready, 0);
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_pkt_count", pkt_count, 0);
    chk("rst_drop_count", drop_count, 0);
    chk("rst_overflow", overflow, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(1);

    // Directed vector table: 3-word packet, read with one stall.
    for (int i = 0; i < 7; i++) begin
      s_axis_tvalid = tbl[i].tv;
      s_axis_tdata  = tbl[i].td;
      s_axis_tlast  = tbl[i].tl;
      m_axis_tready = tbl[i].mr;
      step();
      chk("tbl_valid", m_axis_tvalid, tbl[i].ev);
      if (tbl[i].ev) begin
        chk("tbl_data", m_axis_tdata, tbl[i].ed);
        chk("tbl_last", m_axis_tlast, tbl[i].el);
      end
      chk("tbl_pkt", pkt_count, tbl[i].ep);
    end

    // 10-word packet, descending data, sink always ready.
    m_axis_tready = 1'b1;
    send_pkt(16'hFFFF, 10, -1);
    idle(14);
    chk("t1_drop", drop_count, 0);

    // Sink stalled: A fits, B overflows at its 7th word.
    m_axis_tready = 1'b0;
    send_pkt(16'hA000, 10, 1);
    chk("t2_pkt_after_a", pkt_count, 1);
    send_pkt(16'hB000, 10, 1);
    chk("t2_drop", drop_count, 1);
    m_axis_tready = 1'b1;
    idle(14);

    // Oversized packet into an empty FIFO, then a short one.
    send_pkt(16'h5000, 20, 1);
    chk("t3_drop", drop_count, 2);
    send_pkt(16'h0001, 3, 1);
    idle(6);

    // Asynchronous reset with two committed packets and one partial.
    m_axis_tready = 1'b0;
    send_pkt(16'h1100, 3, 1);
    send_pkt(16'h2200, 3, 1);
    send_beat(16'h3300, 1'b0);
    send_beat(16'h3301, 1'b0);
    s_axis_tvalid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("t5_m_tvalid", m_axis_tvalid, 0);
    chk("t5_pkt_count", pkt_count, 0);
    chk("t5_drop_count", drop_count, 0);
    chk("t5_s_tready", s_axis_tready, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_axis_tready = 1'b1;
    idle(1);
    send_pkt(16'h4440, 4, 1);
    idle(6);

    // Saturation of the 2-bit drop counter: fill exactly, then 5 drops.
    m_axis_tready = 1'b0;
    send_pkt(16'h6000, 16, 1);
    ov_pulses = 0;
    for (int i = 0; i < 5; i++) begin
      send_beat(16'h7000 + 16'(i), 1'b1);
      if (sat_overflow) ov_pulses++;
    end
    s_axis_tvalid = 1'b0;
    idle(1);
    if (sat_overflow) ov_pulses++;
    chk("t6_ov_pulses", ov_pulses, 5);
    chk("t6_sat_drop", sat_drop_count, 3);
    m_axis_tready = 1'b1;
    idle(20);

    // Random traffic with random sink backpressure.
    for (int p = 0; p < 50; p++) begin
      int len;
      len = $urandom_range(1, 8);
      for (int b = 0; b < len; b++) begin
        while ($urandom_range(0, 3) == 0) begin
          s_axis_tvalid = 1'b0;
          m_axis_tready = $urandom_range(0, 1) == 1;
          step();
        end
        m_axis_tready = $urandom_range(0, 1) == 1;
        send_beat(DW'($urandom), b == len - 1);
      end
    end
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    idle(40);
    chk("t4_drained", m_axis_tvalid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
